// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer: state codes,
// default widths and the opcode names understood by the lab ALU.
package alu_op_sequencer_pkg;

  localparam int DEF_DW  = 4;
  localparam int DEF_OPW = 3;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam logic [DEF_OPW-1:0] OP_EQ  = 3'b000;
  localparam logic [DEF_OPW-1:0] OP_LT  = 3'b001;
  localparam logic [DEF_OPW-1:0] OP_XOR = 3'b010;
  localparam logic [DEF_OPW-1:0] OP_OR  = 3'b011;
  localparam logic [DEF_OPW-1:0] OP_AND = 3'b100;
  localparam logic [DEF_OPW-1:0] OP_NOT = 3'b101;
  localparam logic [DEF_OPW-1:0] OP_SUB = 3'b110;
  localparam logic [DEF_OPW-1:0] OP_ADD = 3'b111;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bus between the sequencer and the combinational ALU.
// There is no valid/ready handshake on this bus: the sequencer (master)
// holds alu_a/alu_b/alu_op stable between its load edges, and the ALU
// (slave) answers combinationally; the master samples the answer one
// full cycle after the opcode edge.
interface alu_op_sequencer_if
  import alu_op_sequencer_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int OPW = DEF_OPW
);

  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_result;
  logic           alu_carry;
  logic           alu_overflow;

  modport master (
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_carry, alu_overflow
  );

  modport slave (
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_carry, alu_overflow
  );

endinterface

// File: rtl/alu_op_sequencer_btn_pulse.sv
// Button conditioner: two-flop synchronizer plus a previous-value flop,
// giving a single-cycle pulse on each rising edge of the raw level.
module btn_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronize the raw level and remember last cycle's synchronized value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer in front of and behind the lab's combinational ALU: loads
// A, B and opcode from the switches on successive load presses, captures
// the ALU answer one cycle later, and can chain that answer into A.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int OPW = DEF_OPW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DW-1:0]       sw,
  input  logic                btn_load,
  input  logic                btn_chain,
  input  logic                btn_clr,
  alu_op_sequencer_if.master  alu_bus,
  output logic [DW-1:0]       out_result,
  output logic                out_carry,
  output logic                out_overflow,
  output logic [2:0]          state,
  output logic                done
);

  logic load_p;
  logic chain_p;
  logic clr_p;

  btn_pulse u_load  (.clk(clk), .rst_n(rst_n), .btn(btn_load),  .pulse(load_p));
  btn_pulse u_chain (.clk(clk), .rst_n(rst_n), .btn(btn_chain), .pulse(chain_p));
  btn_pulse u_clr   (.clk(clk), .rst_n(rst_n), .btn(btn_clr),   .pulse(clr_p));

  state_t state_q;
  state_t state_d;

  logic [DW-1:0]  a_q;
  logic [DW-1:0]  b_q;
  logic [OPW-1:0] op_q;

  // Register enables decoded from state and button pulses
  logic clr_en;
  logic ld_a_sw;
  logic ld_a_chain;
  logic ld_b;
  logic ld_op;
  logic capture;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_A;
    else        state_q <= state_d;
  end

  // Next-state logic; clear beats chain beats load
  always_comb begin
    state_d = state_q;
    if (clr_p) begin
      state_d = S_A;
    end else begin
      case (state_q)
        S_A:     if (load_p) state_d = S_B;
        S_B:     if (load_p) state_d = S_OP;
        S_OP:    if (load_p) state_d = S_EXEC;
        S_EXEC:  state_d = S_SHOW;
        S_SHOW:  if (chain_p || load_p) state_d = S_B;
        default: state_d = S_A;
      endcase
    end
  end

  // Output decode: which register loads this cycle (none in S_EXEC except capture)
  always_comb begin
    clr_en     = 1'b0;
    ld_a_sw    = 1'b0;
    ld_a_chain = 1'b0;
    ld_b       = 1'b0;
    ld_op      = 1'b0;
    capture    = 1'b0;
    if (clr_p) begin
      clr_en = 1'b1;
    end else begin
      case (state_q)
        S_A:    ld_a_sw = load_p;
        S_B:    ld_b    = load_p;
        S_OP:   ld_op   = load_p;
        S_EXEC: capture = 1'b1;
        S_SHOW: begin
          if (chain_p)     ld_a_chain = 1'b1;
          else if (load_p) ld_a_sw    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand registers feeding the ALU; only move on their own load edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (clr_en) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else begin
      if (ld_a_sw)    a_q  <= sw;
      if (ld_a_chain) a_q  <= out_result;
      if (ld_b)       b_q  <= sw;
      if (ld_op)      op_q <= sw[OPW-1:0];
    end
  end

  // Display registers and the done pulse, which follows the capture edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result   <= '0;
      out_carry    <= 1'b0;
      out_overflow <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= capture;
      if (clr_en) begin
        out_result   <= '0;
        out_carry    <= 1'b0;
        out_overflow <= 1'b0;
      end else if (capture) begin
        out_result   <= alu_bus.alu_result;
        out_carry    <= alu_bus.alu_carry;
        out_overflow <= alu_bus.alu_overflow;
      end
    end
  end

  assign alu_bus.alu_a  = a_q;
  assign alu_bus.alu_b  = b_q;
  assign alu_bus.alu_op = op_q;
  assign state          = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a reference ALU sits on the slave side of
// the bus, expected captures are queued when the opcode is loaded and
// compared when done pulses.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int DW  = 4;
  localparam int OPW = 3;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] sw;
  logic          btn_load;
  logic          btn_chain;
  logic          btn_clr;
  logic [DW-1:0] out_result;
  logic          out_carry;
  logic          out_overflow;
  logic [2:0]    state;
  logic          done;

  alu_op_sequencer_if #(.DW(DW), .OPW(OPW)) bus ();

  alu_op_sequencer #(.DW(DW), .OPW(OPW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .btn_load     (btn_load),
    .btn_chain    (btn_chain),
    .btn_clr      (btn_clr),
    .alu_bus      (bus),
    .out_result   (out_result),
    .out_carry    (out_carry),
    .out_overflow (out_overflow),
    .state        (state),
    .done         (done)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference ALU: {carry, overflow, result} ----------------
  function automatic logic [5:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    logic       v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[3:0]; c = s[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 5'd1;
        r = s[3:0]; c = s[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      OP_EQ:  r = (a == b) ? 4'd1 : 4'd0;
      OP_LT:  r = (a < b) ? 4'd1 : 4'd0;
      OP_XOR: r = a ^ b;
      OP_OR:  r = a | b;
      OP_AND: r = a & b;
      OP_NOT: r = ~a;
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  always_comb begin
    {bus.alu_carry, bus.alu_overflow, bus.alu_result} =
      alu_model(bus.alu_a, bus.alu_b, bus.alu_op);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];
  logic [3:0] exp_a;
  logic [3:0] exp_b;
  logic [3:0] last_res;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic       done_d = 1'b0;
  logic [5:0] e;

  // Compare each capture against the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      check("done_width", {31'd0, done_d}, 32'd0);
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result",   {28'd0, out_result},   {28'd0, e[3:0]});
        check("carry",    {31'd0, out_carry},    {31'd0, e[5]});
        check("overflow", {31'd0, out_overflow}, {31'd0, e[4]});
        check("done_state", {29'd0, state}, 32'd4);
      end
    end
    done_d = done;
  end

  // ---------------- driver tasks ----------------
  // which: 0=load, 1=chain, 2=clr. Action lands on the third posedge.
  task automatic press(input int which, input logic [3:0] val);
    @(negedge clk);
    sw = val;
    if (which == 0) btn_load  = 1'b1;
    if (which == 1) btn_chain = 1'b1;
    if (which == 2) btn_clr   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    btn_load = 1'b0; btn_chain = 1'b0; btn_clr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic load_a(input logic [3:0] v);
    press(0, v);
    exp_a = v;
    check("load_a_val",   {28'd0, bus.alu_a}, {28'd0, v});
    check("load_a_state", {29'd0, state}, 32'd1);
  endtask

  task automatic load_b(input logic [3:0] v);
    press(0, v);
    exp_b = v;
    check("load_b_val",   {28'd0, bus.alu_b}, {28'd0, v});
    check("load_b_state", {29'd0, state}, 32'd2);
  endtask

  task automatic load_op(input logic [2:0] op);
    logic [5:0] m;
    m = alu_model(exp_a, exp_b, op);
    exp_q.push_back(m);
    last_res = m[3:0];
    press(0, {1'b0, op});
    check("load_op_val",   {29'd0, bus.alu_op}, {29'd0, op});
    check("show_state",    {29'd0, state}, 32'd4);
  endtask

  task automatic chain();
    press(1, 4'd0);
    exp_a = last_res;
    check("chain_a",     {28'd0, bus.alu_a}, {28'd0, last_res});
    check("chain_state", {29'd0, state}, 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, {29'd0, state}, 32'd0);
    check({tag, "_a"},   {28'd0, bus.alu_a},  32'd0);
    check({tag, "_b"},   {28'd0, bus.alu_b},  32'd0);
    check({tag, "_op"},  {29'd0, bus.alu_op}, 32'd0);
    check({tag, "_res"}, {28'd0, out_result}, 32'd0);
    check({tag, "_c"},   {31'd0, out_carry},  32'd0);
    check({tag, "_v"},   {31'd0, out_overflow}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; sw = '0;
    btn_load = 1'b0; btn_chain = 1'b0; btn_clr = 1'b0;
    exp_a = '0; exp_b = '0; last_res = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Held load button: one advance only, acting on the second edge after first sample
    sw = 4'b1010; btn_load = 1'b1;
    @(posedge clk); @(negedge clk);
    check("hold_edge0", {29'd0, state}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("hold_edge1", {29'd0, state}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("hold_edge2_state", {29'd0, state}, 32'd1);
    check("hold_edge2_a", {28'd0, bus.alu_a}, 32'hA);
    repeat (20) @(negedge clk);
    check("hold_stay_state", {29'd0, state}, 32'd1);
    check("hold_stay_b", {28'd0, bus.alu_b}, 32'd0);
    btn_load = 1'b0;
    repeat (4) @(negedge clk);

    press(2, 4'd0);
    check_all_zero("clr");

    // Add with signed overflow, then chain into a second add
    load_a(4'b0101); load_b(4'b0011); load_op(OP_ADD);
    drain();
    check("add_res", {28'd0, out_result}, 32'h8);
    chain();
    load_b(4'b1000); load_op(OP_ADD);
    drain();
    check("chain_res", {28'd0, out_result}, 32'h0);
    check("chain_c", {31'd0, out_carry}, 32'd1);
    check("chain_v", {31'd0, out_overflow}, 32'd1);

    // Randomised calculations, mixing fresh loads and chains
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) chain();
      else load_a(4'($urandom_range(0, 15)));
      load_b(4'($urandom_range(0, 15)));
      load_op(3'($urandom_range(0, 7)));
    end
    drain();

    // Subtract from S_SHOW: load starts a new calculation
    load_a(4'b0011); load_b(4'b0101); load_op(OP_SUB);
    drain();
    check("sub_res", {28'd0, out_result}, 32'hE);

    // Clear and load on the same edge while in S_OP: clear wins
    load_a(4'b0110); load_b(4'b0111);
    @(negedge clk);
    sw = 4'b0101; btn_clr = 1'b1; btn_load = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("clr_op");
    btn_clr = 1'b0; btn_load = 1'b0;
    repeat (6) @(negedge clk);
    check("clr_op_stay", {29'd0, state}, 32'd0);

    // Async reset between edges in S_SHOW
    load_a(4'b0101); load_b(4'b0011); load_op(OP_ADD);
    drain();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    load_a(4'b0001); load_b(4'b0001); load_op(OP_EQ);
    drain();
    check("eq_res", {28'd0, out_result}, 32'h1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequential front/back end for the 4-bit combinational ALU in the lab datapath.
- Collects operand A, operand B and the 3-bit opcode from a shared switch bank, one per load-button press, and drives them to the ALU.
- Captures the ALU's Result, Carry and Overflow into display registers one cycle after the opcode is loaded.
- A chain button feeds the captured result back as the next operand A, so multi-step calculations need no re-entry.

Parameters:
- DW, 4, operand/result width; must match the ALU.
- OPW, 3, opcode width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  DW  raw switch data; opcode uses sw[OPW-1:0].
- btn_load  in  1  load/advance button, raw level, pre-debounced.
- btn_chain  in  1  chain button, raw level, pre-debounced.
- btn_clr  in  1  clear button, raw level, pre-debounced.
- alu_a  out  DW  operand A to ALU.
- alu_b  out  DW  operand B to ALU.
- alu_op  out  OPW  opcode to ALU.
- alu_result  in  DW  ALU Result.
- alu_carry  in  1  ALU Carry.
- alu_overflow  in  1  ALU Overflow.
- out_result  out  DW  captured result.
- out_carry  out  1  captured carry.
- out_overflow  out  1  captured overflow.
- state  out  3  current FSM state code, for LEDs.
- done  out  1  one-cycle pulse when a result is captured.

Behaviour:
- Reset (async, rst_n=0) forces every output register to 0 and state to S_A (code 0).
  - Applies to alu_a, alu_b, alu_op, out_result, out_carry, out_overflow and done.
  - Also clears all synchronizer and edge flops.
  - Reset mid-sequence discards partial operands.
- Button conditioning, per button:
  - 2-flop synchronizer plus a previous-value flop.
  - pulse = sync2 & ~prev.
  - A raw input first sampled high at edge n acts at edge n+2.
  - Holding the button high yields exactly one pulse. A new pulse needs the input to be sampled low for at least one edge first.
- Priority when pulses coincide in the same cycle: clr > chain > load.
- clr pulse, in any state:
  - Moves to S_A and clears alu_a, alu_b, alu_op, out_result, out_carry and out_overflow.
  - done=0.
- FSM states (codes in brackets):
  - S_A (0): load pulse → alu_a<=sw; go to S_B.
  - S_B (1): load pulse → alu_b<=sw; go to S_OP.
  - S_OP (2): load pulse → alu_op<=sw[OPW-1:0]; go to S_EXEC.
  - S_EXEC (3): unconditional, exactly one cycle.
    - ALU inputs have been stable since the S_OP edge.
    - Capture out_result<=alu_result, out_carry<=alu_carry, out_overflow<=alu_overflow.
    - Pulse done=1 for that one cycle; go to S_SHOW.
    - Button pulses arriving during S_EXEC are dropped, except clr.
  - S_SHOW (4):
    - Outputs held.
    - load pulse → alu_a<=sw; go to S_B (a new calculation starts).
    - chain pulse → alu_a<=out_result; go to S_B.
  - Chain pulses outside S_SHOW are ignored.
  - Codes 5–7 are unreachable; if reached, return to S_A on the next edge with no register changes.
- Latency: the opcode load edge is followed by the capture edge one clock later. done is high in the cycle following the capture edge.
- out_* registers change only at S_EXEC capture, clr or reset.
- alu_a, alu_b and alu_op change only on their load edges, chain, clr or reset, so the combinational ALU sees glitch-free inputs.
- No arithmetic in this block. The widths of captured values equal the ALU widths exactly, with no extension or truncation.

Decomposition:
- Shared package holds:
  - the state encodings S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4;
  - DW/OPW defaults;
  - named opcode constants: OP_EQ=000, OP_LT=001, OP_XOR=010, OP_OR=011, OP_AND=100, OP_NOT=101, OP_SUB=110, OP_ADD=111.
- One sub-module, btn_pulse: synchronizer plus rising-edge detector, instantiated three times.
- The FSM and registers stay in the top module.
- The ALU itself is instantiated beside this block by the integrator, not inside it.

Test Plan:
- Add with signed overflow: load sw=0101, 0011, 111 → at capture, out_result=1000, out_carry=0, out_overflow=1; done high exactly one cycle; state=4.
- Subtract: load sw=0011, 0101, 110 → out_result=1110, out_carry=0, out_overflow=0.
- Chain after the add test: chain pulse (alu_a becomes 1000), load sw=1000, then 111 → out_result=0000, out_carry=1, out_overflow=1.
- Hold btn_load high for 20 cycles while in S_A with sw=1010 → alu_a=1010, state=1, no further advance; pulse timing is action at the second edge after first high sample.
- Clear mid-operation: in S_OP assert btn_clr and btn_load on the same edge → state=0 and all operand/result outputs 0; sw is not loaded.
- Async reset asserted between clock edges in S_SHOW → outputs 0 immediately, without waiting for a clock edge. After release, a full sequence 0001, 0001, 000 → out_result=0001 (equality true).
